// File: rtl/dma_channel_scheduler.sv
// -----------------------------------------------------------------------------
// dma_channel_scheduler
//
// Round-robin scheduler that lets NUM_CH DMA requester channels share a single
// transfer splitter. One channel is granted at a time. Its descriptor is copied
// into the conf_* registers and announced to the splitter with a one-cycle
// conf_valid strobe. The scheduler then waits for conf_transaction_done and
// reports completion back to the owning channel.
//
// Descriptors with size zero finish locally without an error. Descriptors with
// bit 31 of the size set are rejected locally with an error. Neither kind is
// issued to the splitter. A watchdog aborts a transfer whose splitter never
// answers.
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   ch_req[NUM_CH]             per-channel request, held until ch_ack
//   ch_addr_host/_device/size  packed 32-bit descriptors, channel k at [32k+:32]
//   ch_dir_write[NUM_CH]       1 = write to host, 0 = read from host
//   ch_ack/ch_done/ch_err      one-hot single-cycle pulses to the owner channel
//   conf_*                     registered descriptor and load strobe to the splitter
//   conf_transaction_done      splitter completion pulse, honoured only while waiting
//   busy, active_ch            status: engine not idle, index of the granted channel
// -----------------------------------------------------------------------------
module dma_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [32*NUM_CH-1:0]  ch_addr_host,
  input  logic [32*NUM_CH-1:0]  ch_addr_device,
  input  logic [32*NUM_CH-1:0]  ch_size,
  input  logic [NUM_CH-1:0]     ch_dir_write,
  output logic [NUM_CH-1:0]     ch_ack,
  output logic [NUM_CH-1:0]     ch_done,
  output logic [NUM_CH-1:0]     ch_err,
  output logic [31:0]           conf_start_address_host,
  output logic [31:0]           conf_start_address_device,
  output logic [31:0]           conf_size,
  output logic                  conf_dir_write,
  output logic                  conf_valid,
  input  logic                  conf_transaction_done,
  output logic                  busy,
  output logic [3:0]            active_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The watchdog fires on the cycle whose counter value equals the last allowed
  // value. A timeout of zero turns the watchdog off entirely.
  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [4:0]      NUM_CH5 = 5'(NUM_CH);

  state_e            state_q, state_d;
  logic [3:0]        rrPtr_q, rrPtr_d;
  logic [3:0]        activeCh_q, activeCh_d;
  logic [31:0]       confHost_q, confHost_d;
  logic [31:0]       confDev_q, confDev_d;
  logic [31:0]       confSize_q, confSize_d;
  logic              confDir_q, confDir_d;
  logic [CNT_W-1:0]  wdCnt_q, wdCnt_d;
  logic              errFlag_q, errFlag_d;

  logic [15:0]       reqExt;
  logic [15:0]       dirExt;
  logic [15:0][31:0] hostArr;
  logic [15:0][31:0] devArr;
  logic [15:0][31:0] sizeArr;

  logic              grantFound;
  logic [3:0]        grantIdx;
  logic [4:0]        cand;
  logic              sizeIssuable;
  logic [NUM_CH-1:0] ownerOh;

  // The channel vectors are widened to the full 16-channel index space so that
  // a 4-bit channel index always selects within range, whatever NUM_CH is.
  assign reqExt = 16'(ch_req);
  assign dirExt = 16'(ch_dir_write);

  for (genvar k = 0; k < 16; k++) begin : g_unpack
    if (k < NUM_CH) begin : g_live
      assign hostArr[k] = ch_addr_host[32*k +: 32];
      assign devArr[k]  = ch_addr_device[32*k +: 32];
      assign sizeArr[k] = ch_size[32*k +: 32];
    end else begin : g_pad
      assign hostArr[k] = '0;
      assign devArr[k]  = '0;
      assign sizeArr[k] = '0;
    end
  end

  // Round-robin search starting one past the last granted channel. Because the
  // pointer is always below NUM_CH, a single conditional subtract is enough to
  // wrap the candidate index, so no divider is needed.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, rrPtr_q} + 5'(i);
      if (cand >= NUM_CH5) begin
        cand = cand - NUM_CH5;
      end
      if (!grantFound && reqExt[cand[3:0]]) begin
        grantFound = 1'b1;
        grantIdx   = cand[3:0];
      end
    end
  end

  // A descriptor goes to the splitter only when its size is non-zero and the
  // top bit is clear; anything else is finished locally.
  assign sizeIssuable = (confSize_q != 32'd0) && !confSize_q[31];

  // Next-state logic. The descriptor registers change only when a grant is made
  // in IDLE, so the splitter sees stable values for the whole transfer and
  // afterwards. The error flag is decided on entry to DONE and shown there.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    activeCh_d = activeCh_q;
    confHost_d = confHost_q;
    confDev_d  = confDev_q;
    confSize_d = confSize_q;
    confDir_d  = confDir_q;
    wdCnt_d    = wdCnt_q;
    errFlag_d  = errFlag_q;

    case (state_q)
      IDLE: begin
        if (grantFound) begin
          confHost_d = hostArr[grantIdx];
          confDev_d  = devArr[grantIdx];
          confSize_d = sizeArr[grantIdx];
          confDir_d  = dirExt[grantIdx];
          activeCh_d = grantIdx;
          rrPtr_d    = grantIdx;
          errFlag_d  = 1'b0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (confSize_q == 32'd0) begin
          errFlag_d = 1'b0;
          state_d   = DONE;
        end else if (confSize_q[31]) begin
          errFlag_d = 1'b1;
          state_d   = DONE;
        end else begin
          wdCnt_d = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A completion arriving on the timeout cycle takes priority, so the
        // transfer is reported as successful.
        if (conf_transaction_done) begin
          errFlag_d = 1'b0;
          state_d   = DONE;
        end else begin
          wdCnt_d = wdCnt_q + CNT_W'(1);
          if (WD_EN && (wdCnt_q == TO_LAST)) begin
            errFlag_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. The pointer resets to the last channel so
  // that channel 0 wins the first arbitration after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= 4'(NUM_CH - 1);
      activeCh_q <= '0;
      confHost_q <= '0;
      confDev_q  <= '0;
      confSize_q <= '0;
      confDir_q  <= 1'b0;
      wdCnt_q    <= '0;
      errFlag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      activeCh_q <= activeCh_d;
      confHost_q <= confHost_d;
      confDev_q  <= confDev_d;
      confSize_q <= confSize_d;
      confDir_q  <= confDir_d;
      wdCnt_q    <= wdCnt_d;
      errFlag_q  <= errFlag_d;
    end
  end

  // Handshake pulses are decoded from the registered state, so each is exactly
  // one cycle long and only the owner channel's bit can ever be set.
  assign ownerOh = {{(NUM_CH-1){1'b0}}, 1'b1} << activeCh_q;

  always_comb begin
    ch_ack     = '0;
    ch_done    = '0;
    ch_err     = '0;
    conf_valid = 1'b0;
    case (state_q)
      ISSUE: begin
        ch_ack     = ownerOh;
        conf_valid = sizeIssuable;
      end
      DONE: begin
        ch_done = ownerOh;
        if (errFlag_q) begin
          ch_err = ownerOh;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy                      = (state_q != IDLE);
  assign active_ch                 = activeCh_q;
  assign conf_start_address_host   = confHost_q;
  assign conf_start_address_device = confDev_q;
  assign conf_size                 = confSize_q;
  assign conf_dir_write            = confDir_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dma_channel_scheduler
//
// Self-checking bench for dma_channel_scheduler. A transaction-level reference
// model (pending flags, stored descriptors, a round-robin pointer) predicts the
// granted channel, the descriptor seen by the splitter, whether it is issued,
// and when and how each transfer completes. Directed scenarios come first,
// followed by randomized traffic and a mid-transfer reset.
// -----------------------------------------------------------------------------
module tb_dma_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int TO     = 10;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [NUM_CH-1:0]    chReq;
  logic [32*NUM_CH-1:0] chAddrHost;
  logic [32*NUM_CH-1:0] chAddrDev;
  logic [32*NUM_CH-1:0] chSize;
  logic [NUM_CH-1:0]    chDirWrite;
  logic [NUM_CH-1:0]    chAck;
  logic [NUM_CH-1:0]    chDone;
  logic [NUM_CH-1:0]    chErr;
  logic [31:0]          confHost;
  logic [31:0]          confDev;
  logic [31:0]          confSize;
  logic                 confDir;
  logic                 confValid;
  logic                 confDone;
  logic                 busy;
  logic [3:0]           activeCh;

  int checks   = 0;
  int errors   = 0;
  int cycleCnt = 0;

  // Reference model state
  int          rrPtr;
  bit          pending [NUM_CH];
  logic [31:0] mHost   [NUM_CH];
  logic [31:0] mDev    [NUM_CH];
  logic [31:0] mSize   [NUM_CH];
  logic        mDir    [NUM_CH];

  int validCycle;
  int obsGrant;

  dma_channel_scheduler #(
    .NUM_CH(NUM_CH),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(16)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .ch_req(chReq),
    .ch_addr_host(chAddrHost),
    .ch_addr_device(chAddrDev),
    .ch_size(chSize),
    .ch_dir_write(chDirWrite),
    .ch_ack(chAck),
    .ch_done(chDone),
    .ch_err(chErr),
    .conf_start_address_host(confHost),
    .conf_start_address_device(confDev),
    .conf_size(confSize),
    .conf_dir_write(confDir),
    .conf_valid(confValid),
    .conf_transaction_done(confDone),
    .busy(busy),
    .active_ch(activeCh)
  );

  always #5 i_clk = ~i_clk;

  // Compare one observed value with its expected value and log any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cycleCnt);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs driven
  task automatic tick();
    @(negedge i_clk);
    cycleCnt++;
  endtask

  function automatic logic stray();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic postRequest(input int c, input logic [31:0] h, input logic [31:0] d,
                             input logic [31:0] s, input logic w);
    mHost[c]   = h;
    mDev[c]    = d;
    mSize[c]   = s;
    mDir[c]    = w;
    pending[c] = 1'b1;
    chAddrHost[32*c +: 32] = h;
    chAddrDev[32*c +: 32]  = d;
    chSize[32*c +: 32]     = s;
    chDirWrite[c]          = w;
    chReq[c]               = 1'b1;
  endtask

  task automatic clearRequests();
    for (int c = 0; c < NUM_CH; c++) begin
      pending[c] = 1'b0;
      chReq[c]   = 1'b0;
    end
  endtask

  // First pending channel after the pointer, wrapping around the channel count
  function automatic int expectedGrant();
    for (int i = 1; i <= NUM_CH; i++) begin
      if (pending[(rrPtr + i) % NUM_CH]) return (rrPtr + i) % NUM_CH;
    end
    return -1;
  endfunction

  // Run one arbitration round from a falling edge where the scheduler is idle.
  // k is the WAIT cycle (1 = first WAIT cycle) on which the splitter answers;
  // values outside 1..TO mean the splitter stays silent until the timeout.
  task automatic applyStimulus(input int k);
    int          g;
    int          doneAt;
    bit          issue;
    bit          expErr;
    logic [31:0] oh;
    g = expectedGrant();
    if (g < 0) begin
      tick();
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("idle_ack", 32'(chAck), 32'd0);
      confDone = stray();
      return;
    end
    oh    = 32'd1 << g;
    issue = (mSize[g] != 32'd0) && !mSize[g][31];

    tick();
    checkOutput("ack", 32'(chAck), oh);
    checkOutput("conf_valid", {31'd0, confValid}, {31'd0, issue});
    checkOutput("conf_host", confHost, mHost[g]);
    checkOutput("conf_dev", confDev, mDev[g]);
    checkOutput("conf_size", confSize, mSize[g]);
    checkOutput("conf_dir", {31'd0, confDir}, {31'd0, mDir[g]});
    checkOutput("active_ch", 32'(activeCh), 32'(g));
    checkOutput("issue_busy", {31'd0, busy}, 32'd1);
    obsGrant = int'(activeCh);
    if (issue) validCycle = cycleCnt;
    chReq[g]   = 1'b0;
    pending[g] = 1'b0;
    rrPtr      = g;
    confDone   = stray();

    if (!issue) begin
      doneAt = 1;
      expErr = (mSize[g] != 32'd0);
    end else if (k >= 1 && k <= TO) begin
      doneAt = k + 1;
      expErr = 1'b0;
    end else begin
      doneAt = TO + 1;
      expErr = 1'b1;
    end

    for (int j = 1; j <= doneAt; j++) begin
      tick();
      if (j < doneAt) begin
        checkOutput("early_done", 32'(chDone), 32'd0);
        checkOutput("wait_valid", {31'd0, confValid}, 32'd0);
        checkOutput("wait_busy", {31'd0, busy}, 32'd1);
        confDone = issue && (j == k);
      end else begin
        checkOutput("done", 32'(chDone), oh);
        checkOutput("err", 32'(chErr), expErr ? oh : 32'd0);
        checkOutput("done_valid", {31'd0, confValid}, 32'd0);
        confDone = stray();
      end
    end

    tick();
    checkOutput("ret_busy", {31'd0, busy}, 32'd0);
    checkOutput("ret_done", 32'(chDone), 32'd0);
    checkOutput("hold_size", confSize, mSize[g]);
    confDone = stray();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int          prevValid;
    logic [31:0] sz;
    i_rst      = 1'b1;
    chReq      = '0;
    chAddrHost = '0;
    chAddrDev  = '0;
    chSize     = '0;
    chDirWrite = '0;
    confDone   = 1'b0;
    rrPtr      = NUM_CH - 1;
    for (int c = 0; c < NUM_CH; c++) pending[c] = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_active", 32'(activeCh), 32'd0);
    checkOutput("rst_valid", {31'd0, confValid}, 32'd0);
    checkOutput("rst_host", confHost, 32'd0);
    checkOutput("rst_dev", confDev, 32'd0);
    checkOutput("rst_size", confSize, 32'd0);
    checkOutput("rst_dir", {31'd0, confDir}, 32'd0);
    checkOutput("rst_ack", 32'(chAck), 32'd0);
    checkOutput("rst_done", 32'(chDone), 32'd0);
    checkOutput("rst_err", 32'(chErr), 32'd0);
    i_rst = 1'b0;

    // Fairness: all channels request continuously, splitter answers after 5
    for (int c = 0; c < NUM_CH; c++) postRequest(c, $urandom, $urandom, 32'h40 * (c + 1), c[0]);
    prevValid = 0;
    for (int r = 0; r < 6; r++) begin
      applyStimulus(5);
      checkOutput("rr_order", 32'(obsGrant), 32'(r % NUM_CH));
      if (r > 0) checkOutput("rr_spacing", 32'(validCycle - prevValid), 32'd8);
      prevValid = validCycle;
      postRequest(r % NUM_CH, $urandom, $urandom, 32'h100 + 32'(r), 1'b0);
    end
    clearRequests();

    // Single read request on channel 0
    postRequest(0, 32'h1000, 32'h0, 32'h200, 1'b0);
    applyStimulus(8);
    checkOutput("single_grant", 32'(obsGrant), 32'd0);

    // Zero-size and oversize descriptors complete locally
    postRequest(2, 32'hA000, 32'hB000, 32'h0, 1'b1);
    applyStimulus(3);
    postRequest(2, 32'hA000, 32'hB000, 32'h8000_0000, 1'b1);
    applyStimulus(3);

    // Watchdog with a silent splitter, then a stray done that must be ignored
    postRequest(1, 32'h2000, 32'h3000, 32'h100, 1'b1);
    applyStimulus(0);
    confDone = 1'b1;
    tick();
    tick();
    confDone = 1'b0;
    checkOutput("stray_busy", {31'd0, busy}, 32'd0);
    checkOutput("stray_done", 32'(chDone), 32'd0);
    postRequest(1, 32'h2100, 32'h3100, 32'h10, 1'b0);
    applyStimulus(4);

    // Completion on the timeout cycle wins
    postRequest(3, 32'h4000, 32'h5000, 32'h20, 1'b0);
    applyStimulus(TO);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!pending[c] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 5))
            0:       sz = 32'h0;
            1:       sz = 32'h8000_0000 | $urandom;
            default: sz = ($urandom & 32'h7FFF_FFFF) | 32'h1;
          endcase
          postRequest(c, $urandom, $urandom, sz, 1'($urandom_range(0, 1)));
        end
      end
      applyStimulus($urandom_range(0, 13));
    end
    clearRequests();
    confDone = 1'b0;
    tick();

    // Reset while waiting on the splitter
    postRequest(2, 32'h6000, 32'h7000, 32'h400, 1'b0);
    tick();
    checkOutput("rw_ack", 32'(chAck), 32'd4);
    chReq[2]   = 1'b0;
    pending[2] = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    checkOutput("rw_busy", {31'd0, busy}, 32'd0);
    checkOutput("rw_active", 32'(activeCh), 32'd0);
    checkOutput("rw_done", 32'(chDone), 32'd0);
    checkOutput("rw_size", confSize, 32'd0);
    checkOutput("rw_valid", {31'd0, confValid}, 32'd0);
    i_rst = 1'b0;
    rrPtr = NUM_CH - 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rw_quiet_done", 32'(chDone), 32'd0);
      checkOutput("rw_quiet_busy", {31'd0, busy}, 32'd0);
    end
    for (int c = 0; c < NUM_CH; c++) postRequest(c, 32'h100 * c, 32'h200 * c, 32'h8, 1'b1);
    applyStimulus(2);
    checkOutput("rw_first_grant", 32'(obsGrant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
